// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared constants and helpers for the mult_arbiter block.
//   MULT_LAT : request-to-response latency in cycles with resp_ready held high
//   STAT_W   : width of each per-requester grant counter
//   id_w()   : width of a requester index for a given requester count
package mult_arb_pkg;

  localparam int MULT_LAT = 2;
  localparam int STAT_W   = 16;

  // Requester index width; never narrower than one bit.
  function automatic int id_w(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/mul8s_1KR6.sv
// mul8s_1KR6: multiplier core shared by mult_arbiter.
// Purely combinational signed two's-complement multiply; the surrounding
// pipeline registers its inputs and its output.
// Ports:
//   A, B : signed operands, W bits each
//   O    : signed product, 2*W bits
module mul8s_1KR6 #(
  parameter int W = 8
) (
  input  logic signed [W-1:0]   A,
  input  logic signed [W-1:0]   B,
  output logic signed [2*W-1:0] O
);

  assign O = A * B;

endmodule

// File: rtl/mult_arbiter_rr.sv
// rr_arbiter: stateless round-robin grant logic for mult_arbiter.
// Priority starts at ptr and wraps through the higher indices back to 0.
// Ports:
//   req       : request vector, one bit per requester
//   ptr       : index with the highest priority this cycle
//   grant     : one-hot grant, zero when no request is present
//   grant_idx : encoded index of the granted requester (0 when none)
//   any       : at least one requester is granted
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_idx,
  output logic             any
);

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    // First pass covers ptr..N_REQ-1, second pass wraps to 0..ptr-1.
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && (IDW'(i) >= ptr)) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!any && req[i] && (IDW'(i) < ptr)) begin
        any       = 1'b1;
        grant[i]  = 1'b1;
        grant_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one mul8s_1KR6 core between N_REQ requesters.
// Round-robin arbitration feeds a 2-stage stallable pipeline (operand stage,
// result stage); results leave on one tagged response channel in acceptance
// order.
// Optional feature macro: MULT_ARB_STATS_EN adds per-requester saturating
// 16-bit grant counters on stat_grants.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-requester operand valid
//   req_x, req_y : flattened operands, slice i = [i*W +: W]
//   req_ready    : one-hot (or zero) accept strobe
//   resp_valid   : response valid
//   resp_ready   : consumer accepts the response
//   resp_id      : originating requester index
//   resp_p       : signed product, 2*W bits
//   stat_grants  : (MULT_ARB_STATS_EN only) counter i at [i*16 +: 16]
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  parameter  int W     = 16,
  localparam int IDW   = id_w(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IDW-1:0]     resp_id,
  output logic [2*W-1:0]     resp_p
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0] stat_grants
`endif
);

  logic                  v_p1_q, v_p1_d;
  logic [IDW-1:0]        id_p1_q, id_p1_d;
  logic signed [W-1:0]   x_p1_q, x_p1_d;
  logic signed [W-1:0]   y_p1_q, y_p1_d;

  logic                  v_p2_q, v_p2_d;
  logic [IDW-1:0]        id_p2_q, id_p2_d;
  logic signed [2*W-1:0] p_p2_q, p_p2_d;

  logic [IDW-1:0]        ptr_q, ptr_d;

  logic                  en1, en2, hs;
  logic [N_REQ-1:0]      grant;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_any;
  logic signed [W-1:0]   x_sel, y_sel;
  logic signed [2*W-1:0] core_p;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    en2 = !v_p2_q | resp_ready;
    en1 = !v_p1_q | en2;
    // No request is accepted while reset is held, so nothing slips in during
    // the reset window.
    req_ready = rst ? '0 : (grant & {N_REQ{en1}});
    hs        = grant_any & en1 & !rst;
  end

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        x_sel = req_x[i*W +: W];
        y_sel = req_y[i*W +: W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---- stage p1: operand registers (drive the core) ----
  always_comb begin
    v_p1_d  = v_p1_q;
    id_p1_d = id_p1_q;
    x_p1_d  = x_p1_q;
    y_p1_d  = y_p1_q;
    if (en1) begin
      v_p1_d = hs;
      if (hs) begin
        id_p1_d = grant_idx;
        x_p1_d  = x_sel;
        y_p1_d  = y_sel;
      end
    end
  end

  mul8s_1KR6 #(
    .W (W)
  ) u_core (
    .A (x_p1_q),
    .B (y_p1_q),
    .O (core_p)
  );

  // ---- stage p2: registered core output (drives the response) ----
  always_comb begin
    v_p2_d  = v_p2_q;
    id_p2_d = id_p2_q;
    p_p2_d  = p_p2_q;
    if (en2) begin
      v_p2_d  = v_p1_q;
      id_p2_d = id_p1_q;
      p_p2_d  = core_p;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      v_p1_q  <= 1'b0;
      id_p1_q <= '0;
      x_p1_q  <= '0;
      y_p1_q  <= '0;
      v_p2_q  <= 1'b0;
      id_p2_q <= '0;
      p_p2_q  <= '0;
    end else begin
      ptr_q   <= ptr_d;
      v_p1_q  <= v_p1_d;
      id_p1_q <= id_p1_d;
      x_p1_q  <= x_p1_d;
      y_p1_q  <= y_p1_d;
      v_p2_q  <= v_p2_d;
      id_p2_q <= id_p2_d;
      p_p2_q  <= p_p2_d;
    end
  end

  assign resp_valid = v_p2_q;
  assign resp_id    = id_p2_q;
  assign resp_p     = p_p2_q;

`ifdef MULT_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [N_REQ];
  logic [STAT_W-1:0] cnt_d [N_REQ];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] c);
    return (c == {STAT_W{1'b1}}) ? c : c + 1'b1;
  endfunction

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = (req_valid[i] & req_ready[i]) ? sat_inc(cnt_q[i]) : cnt_q[i];
      stat_grants[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: self-checking bench for mult_arbiter (N_REQ=4, W=16).
// A fixed vector table covers the single-requester latency case and the
// wrap/skip arbitration case; hand sequences cover fairness, backpressure and
// mid-stream reset; a randomized phase runs against a queue-based reference
// model. With MULT_ARB_STATS_EN the grant counter saturation is also covered.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = id_w(N);

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_x, req_y;
  logic [N-1:0]     req_ready;
  logic             resp_valid;
  logic             resp_ready;
  logic [IDW-1:0]   resp_id;
  logic [2*W-1:0]   resp_p;
`ifdef MULT_ARB_STATS_EN
  logic [N*STAT_W-1:0] stat_grants;
`endif

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_p     (resp_p)
`ifdef MULT_ARB_STATS_EN
    ,
    .stat_grants(stat_grants)
`endif
  );

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    int             id;
    logic [2*W-1:0] p;
    int             acc;
  } item_t;

  typedef struct {
    logic [N-1:0]   vld;
    logic           rr;
    logic [N-1:0]   exp_rdy;
    logic           exp_rv;
    logic [IDW-1:0] exp_id;
    logic [2*W-1:0] exp_p;
  } vec_t;

  item_t        sb[$];
  int           m_ptr = 0;
  int           edges = 0;
  logic [N-1:0] pend = '0;
  logic [W-1:0] sx[N];
  logic [W-1:0] sy[N];
  vec_t         tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] r;
    r = $signed(a) * $signed(b);
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_x[i*W +: W]    = sx[i];
      req_y[i*W +: W]    = sy[i];
    end
  endtask

  // Requesters hold valid and data until their handshake; idle ones start a
  // new request when forced by mask or with probability pct.
  task automatic refill(input logic [N-1:0] mask, input int pct);
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && (mask[i] || ($urandom_range(0, 99) < pct))) begin
        pend[i] = 1'b1;
        sx[i]   = pick();
        sy[i]   = pick();
      end
    end
    drive();
  endtask

  // One clock cycle checked against the reference model. Entered and left
  // 1 time unit after a rising edge.
  task automatic tick(output int dut_g, output bit hs);
    int           g;
    int           idx;
    bit           allow, exp_rv, pop;
    logic [N-1:0] exp_rdy;
    #1;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (g < 0 && req_valid[idx]) g = idx;
    end
    // The pipe holds two operations; a third only fits if one leaves.
    allow   = (sb.size() < 2) || resp_ready;
    exp_rdy = '0;
    if (g >= 0 && allow) exp_rdy[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_rdy));
    exp_rv = (sb.size() > 0) && ((edges - sb[0].acc) >= MULT_LAT - 1);
    chk("resp_valid", 64'(resp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("resp_id", 64'(resp_id), 64'(sb[0].id));
      chk("resp_p", 64'(resp_p), 64'(sb[0].p));
    end
    dut_g = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) dut_g = i;
    hs  = (g >= 0) && allow;
    pop = exp_rv && resp_ready;
    @(posedge clk);
    edges++;
    if (pop) void'(sb.pop_front());
    if (hs) begin
      sb.push_back('{id: g, p: ref_mul(sx[g], sy[g]), acc: edges});
      m_ptr   = (g + 1) % N;
      pend[g] = 1'b0;
    end
    #1;
  endtask

  task automatic finish_reset();
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_ptr = 0;
    pend  = '0;
    drive();
    @(posedge clk);
    edges++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend = '0;
    drive();
    @(posedge clk);
    #1;
    finish_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dg;
    bit hs;
    int cnt;

    tbl[0] = '{vld: 4'b0100, rr: 1'b1, exp_rdy: 4'b0100, exp_rv: 1'b0, exp_id: 2'd0, exp_p: 32'h0};
    tbl[1] = '{vld: 4'b0000, rr: 1'b1, exp_rdy: 4'b0000, exp_rv: 1'b0, exp_id: 2'd0, exp_p: 32'h0};
    tbl[2] = '{vld: 4'b0000, rr: 1'b1, exp_rdy: 4'b0000, exp_rv: 1'b1, exp_id: 2'd2, exp_p: 32'h0};
    tbl[3] = '{vld: 4'b0010, rr: 1'b1, exp_rdy: 4'b0010, exp_rv: 1'b0, exp_id: 2'd0, exp_p: 32'h0};
    tbl[4] = '{vld: 4'b1010, rr: 1'b1, exp_rdy: 4'b1000, exp_rv: 1'b0, exp_id: 2'd0, exp_p: 32'h0};
    tbl[5] = '{vld: 4'b1010, rr: 1'b1, exp_rdy: 4'b0010, exp_rv: 1'b1, exp_id: 2'd1, exp_p: 32'hFFFFFFEB};
    tbl[6] = '{vld: 4'b1010, rr: 1'b1, exp_rdy: 4'b1000, exp_rv: 1'b1, exp_id: 2'd3, exp_p: 32'hC0008000};
    tbl[7] = '{vld: 4'b0000, rr: 1'b1, exp_rdy: 4'b0000, exp_rv: 1'b1, exp_id: 2'd1, exp_p: 32'hFFFFFFEB};
    tbl[8] = '{vld: 4'b0000, rr: 1'b1, exp_rdy: 4'b0000, exp_rv: 1'b1, exp_id: 2'd3, exp_p: 32'hC0008000};
    tbl[9] = '{vld: 4'b0000, rr: 1'b1, exp_rdy: 4'b0000, exp_rv: 1'b0, exp_id: 2'd0, exp_p: 32'h0};

    // Reset values, with every requester asking
    rst        = 1'b1;
    resp_ready = 1'b1;
    sx[0] = 16'h0011; sy[0] = 16'h0022;
    sx[1] = 16'hFFFD; sy[1] = 16'h0007;
    sx[2] = 16'h0000; sy[2] = 16'h1234;
    sx[3] = 16'h7FFF; sy[3] = 16'h8000;
    pend = '1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_resp_id", 64'(resp_id), 64'(0));
    chk("rst_resp_p", 64'(resp_p), 64'(0));
    finish_reset();

    // Vector table: single requester latency, then wrap and skip
    for (int e = 0; e < 10; e++) begin
      req_valid  = tbl[e].vld;
      resp_ready = tbl[e].rr;
      #1;
      chk($sformatf("tbl%0d_req_ready", e), 64'(req_ready), 64'(tbl[e].exp_rdy));
      chk($sformatf("tbl%0d_resp_valid", e), 64'(resp_valid), 64'(tbl[e].exp_rv));
      if (tbl[e].exp_rv) begin
        chk($sformatf("tbl%0d_resp_id", e), 64'(resp_id), 64'(tbl[e].exp_id));
        chk($sformatf("tbl%0d_resp_p", e), 64'(resp_p), 64'(tbl[e].exp_p));
      end
      @(posedge clk);
      #1;
    end

    // Fairness: all four requesters busy for 8 cycles
    do_reset();
    resp_ready = 1'b1;
    refill('1, 0);
    for (int i = 0; i < 8; i++) begin
      tick(dg, hs);
      chk($sformatf("grant_order%0d", i), 64'(dg), 64'(i % N));
      refill('1, 0);
    end

    // Drain, then backpressure with one operation already in the operand stage
    for (int t = 0; t < 20 && pend != '0; t++) begin
      tick(dg, hs);
      refill('0, 0);
    end
    chk("drain_requests", 64'(pend), 64'(0));
    for (int t = 0; t < 10 && sb.size() != 0; t++) tick(dg, hs);
    chk("drain_responses", 64'(resp_valid), 64'(0));
    refill(4'b0001, 0);
    tick(dg, hs);
    resp_ready = 1'b0;
    refill('1, 0);
    cnt = 0;
    for (int t = 0; t < 5; t++) begin
      tick(dg, hs);
      cnt += int'(hs);
      chk($sformatf("bp_ready_count%0d", t), 64'($countones(req_ready) == 0 || t == 0), 64'(1));
      refill('1, 0);
    end
    chk("bp_absorbed", 64'(cnt), 64'(1));
    resp_ready = 1'b1;
    for (int t = 0; t < 12; t++) begin
      tick(dg, hs);
      refill('0, 0);
    end

    // Reset with both stages full
    resp_ready = 1'b0;
    refill('1, 0);
    for (int t = 0; t < 6 && sb.size() < 2; t++) begin
      tick(dg, hs);
      refill('1, 0);
    end
    chk("pipe_full_before_reset", 64'(resp_valid), 64'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_resp_valid", 64'(resp_valid), 64'(0));
    chk("midrst_resp_id", 64'(resp_id), 64'(0));
    chk("midrst_resp_p", 64'(resp_p), 64'(0));
    chk("midrst_req_ready", 64'(req_ready), 64'(0));
    finish_reset();
    resp_ready = 1'b1;
    for (int t = 0; t < 5; t++) tick(dg, hs);

    // Randomized traffic against the reference model
    for (int t = 0; t < 400; t++) begin
      resp_ready = ($urandom_range(0, 99) < 70);
      refill('0, 40);
      tick(dg, hs);
    end
    resp_ready = 1'b1;
    for (int t = 0; t < 30; t++) begin
      refill('0, 0);
      tick(dg, hs);
    end

`ifdef MULT_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < N; i++)
      chk($sformatf("stat_rst%0d", i), 64'(stat_grants[i*STAT_W +: STAT_W]), 64'(0));
    req_valid  = 4'b0001;
    resp_ready = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    req_valid = '0;
    chk("stat_sat0", 64'(stat_grants[0 +: STAT_W]), 64'(16'hFFFF));
    for (int i = 1; i < N; i++)
      chk($sformatf("stat_other%0d", i), 64'(stat_grants[i*STAT_W +: STAT_W]), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares a single registered `mul8s_1KR6` multiplier core between `N_REQ` requesters. Each requester uses its own valid/ready operand port. Grants are round-robin, and the block issues at most one multiply per cycle into a 2-stage stallable pipeline. Results return on one tagged response channel with backpressure. The block sits between client engines and the approximate multiplier and replaces the free-running input/output register wrapper.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `W`, default 16: operand width; the product is `2*W`.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req_valid`  in  N_REQ: requester i has operands on `req_x`/`req_y` slice i.
- `req_x`, `req_y`  in  N_REQ*W: flattened operands; slice i is `[i*W +: W]`.
- `req_ready`  out  N_REQ: one-hot or zero; a handshake occurs on the edge where `req_valid[i] & req_ready[i]`.
- `resp_valid`  out  1: `resp_p`/`resp_id` are valid.
- `resp_ready`  in  1: consumer accepts the response.
- `resp_id`  out  clog2(N_REQ): index of the originating requester.
- `resp_p`  out  2*W: core product of the accepted operands.
- `stat_grants`  out  N_REQ*16: present only with `MULT_ARB_STATS_EN`.

## Operation
- **S1 (operand stage):** registers `v1`, `id1`, `x1`, `y1`, which drive the core inputs.
- **S2 (result stage):** registers `v2`, `id2`, and `p2` (the registered core output). `p2` drives the `resp_*` outputs.
- **Stall logic:** `en2 = !v2 | resp_ready` and `en1 = !v1 | en2`.
- **S2 load:** when `en2`, `v2 <= v1`, `id2 <= id1`, `p2 <= core(x1,y1)`.
- **S1 load:** when `en1`, `v1 <= |(req_valid & req_ready)`. Operands and `id1` load from the granted slice. `x1`, `y1` and `id1` hold when there is no grant.
- **Arbitration:**
  - Combinational round-robin over `req_valid`, starting at pointer `ptr`.
  - `req_ready[g] = grant[g] & en1`.
  - After a handshake with g, `ptr <= (g+1) mod N_REQ`. With no handshake, `ptr` holds.
- **Grant stability:** a grant may move between cycles while `en1` is low. Requesters hold valid and data until their handshake, so this is legal.
- **Ordering:** responses leave in acceptance order. There is no reordering and no dropping.
- **Backpressure:** while `resp_valid & !resp_ready`, `resp_*` are stable. At most one further request is absorbed into S1, then all `req_ready` go low.
- **Arithmetic:** signed two's-complement, as defined by the core. The block never alters the product.

## Timing
- **Reset values:** `req_ready = 0`, `resp_valid = 0`, `resp_id = 0`, `resp_p = 0`, `ptr = 0`, `v1 = v2 = 0`, stat counters 0.
- **Reset mid-operation:** all in-flight operations are discarded and no response is emitted for them.
- **Latency:** a handshake at edge E0 gives `resp_valid` high after edge E1, i.e. 2 cycles request to response when `resp_ready` is high.
- **Throughput:** 1 operation per cycle with continuous `resp_ready`.
- **Simultaneous events:**
  - Response accept and new grant in the same cycle are allowed.
  - If `resp_ready` rises while both stages are full, both advance on the same edge.
- **Empty pipe:** `req_ready` may assert in the same cycle `req_valid` rises; the arbiter path is combinational.
- **Pointer wrap:** after granting `N_REQ-1`, `ptr = 0`.

## Configuration
- **`MULT_ARB_STATS_EN` defined:**
  - Adds `stat_grants`, one 16-bit counter per requester.
  - Counter i increments on each handshake of requester i and saturates at 0xFFFF.
  - Counters clear on `rst`.
- **`MULT_ARB_STATS_EN` undefined:** the port and counters are absent. All other behaviour is identical.

## Structure
- **Package `mult_arb_pkg`:** holds `MULT_LAT = 2`, `STAT_W = 16`, and a function returning the id width for `N_REQ`.
- **Sub-module `rr_arbiter`:** takes requests and the pointer, and produces a one-hot grant plus the encoded index. It contains no state; `ptr` lives in `mult_arbiter`.
- **Core:** `mul8s_1KR6` is instantiated once, unmodified, between S1 and S2.

## Test plan
1. **Reset:** assert `rst` mid-stream with S1 and S2 full -> all outputs 0 at once, and no response after release.
2. **Single requester:** requester 2 sends x=0, y=0x1234, with `resp_ready` high -> `resp_valid` 2 cycles later, `resp_id` = 2, `resp_p` = 0.
3. **Fairness:** all 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; `resp_id` follows the same order; products match the core model.
4. **Backpressure:** hold `resp_ready` low for 5 cycles during a stream -> `resp_*` stable, exactly one more handshake absorbed, then `req_ready` = 0. On release, no loss or duplication and order is preserved.
5. **Wrap and skip:** only requesters 1 and 3 valid, with `ptr` = 2 -> grant 3, then 1, then 3.
6. **Stats (with `MULT_ARB_STATS_EN`):** 70000 handshakes on requester 0 -> counter 0 = 0xFFFF, other counters unchanged.
